// File: rtl/mem_port_arbiter4_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter4_pkg
//  Description : Shared constants, state encoding and index/one-hot helpers
//                for the four-requester memory port arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_port_arbiter4_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    // Arbiter state encoding
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_OWN  = 1'b1;

    // Requester index <-> one-hot grant encodings
    localparam logic [IDX_W-1:0]   IDX_REQ0 = 2'd0;   // instruction fetch
    localparam logic [IDX_W-1:0]   IDX_REQ1 = 2'd1;   // load/store
    localparam logic [IDX_W-1:0]   IDX_REQ2 = 2'd2;   // DMA
    localparam logic [IDX_W-1:0]   IDX_REQ3 = 2'd3;   // debug
    localparam logic [NUM_REQ-1:0] OH_REQ0  = 4'b0001;
    localparam logic [NUM_REQ-1:0] OH_REQ1  = 4'b0010;
    localparam logic [NUM_REQ-1:0] OH_REQ2  = 4'b0100;
    localparam logic [NUM_REQ-1:0] OH_REQ3  = 4'b1000;

    // Binary requester index to one-hot grant vector
    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] oh;
        case (idx)
            IDX_REQ0: oh = OH_REQ0;
            IDX_REQ1: oh = OH_REQ1;
            IDX_REQ2: oh = OH_REQ2;
            IDX_REQ3: oh = OH_REQ3;
            default:  oh = '0;
        endcase
        return oh;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter4_rr_pick4.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick4
//  Description : Combinational round-robin pick over four requesters. The
//                winner is the first set request scanning ptr, ptr+1, ...
//                modulo four.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick4
    import mem_port_arbiter4_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] win_onehot,
    output logic [IDX_W-1:0]   win_idx,
    output logic               any
);

    logic [IDX_W-1:0] w_cand;

    // Cyclic scan from ptr; the first set request wins, later ones are masked
    always_comb begin
        win_idx = '0;
        any     = 1'b0;
        w_cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = ptr + IDX_W'(k);
            if (!any && req[w_cand]) begin
                any     = 1'b1;
                win_idx = w_cand;
            end
        end
    end

    assign win_onehot = any ? idx_to_onehot(win_idx) : '0;

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter4.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter4
//  Description : Round-robin burst arbiter sharing one 32-bit operand port
//                among four requesters. Holds ownership across multi-beat
//                bursts, drives the operand-mux select and forces release
//                after MAX_BEATS accepted beats.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter4
    import mem_port_arbiter4_pkg::*;
#(
    parameter int MAX_BEATS = 16,
    parameter int CNT_W     = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] last,
    input  logic               ready,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   sel,
    output logic               busy,
    output logic               timeout
);

    // Count value on which the final permitted beat is accepted
    localparam logic [CNT_W-1:0] c_last_beat = CNT_W'(MAX_BEATS - 1);

    logic [0:0]         r_state;
    logic [NUM_REQ-1:0] r_grant;
    logic [IDX_W-1:0]   r_sel;
    logic [IDX_W-1:0]   r_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_timeout;

    logic [IDX_W-1:0]   w_owner;
    logic               w_own;
    logic               w_beat;
    logic               w_rel_last;
    logic               w_rel_force;
    logic               w_abandon;
    logic               w_release;
    logic [IDX_W-1:0]   w_pick_ptr;
    logic [NUM_REQ-1:0] w_win_onehot;
    logic [IDX_W-1:0]   w_win_idx;
    logic               w_any;

    // sel always tracks the owner while a grant is held
    assign w_owner = r_sel;
    assign w_own   = (r_state == ST_OWN);

    // Beat and release qualification; only the owner's req/last matter
    assign w_beat      = w_own & req[w_owner] & ready;
    assign w_rel_last  = w_beat & last[w_owner];
    assign w_rel_force = w_beat & ~last[w_owner] & (r_count == c_last_beat);
    assign w_abandon   = w_own & ~req[w_owner];
    assign w_release   = w_rel_last | w_rel_force | w_abandon;

    // On a release the pointer moves past the owner in the same cycle, so the
    // pick below already sees the rotated priority and no bubble is inserted.
    assign w_pick_ptr = w_own ? (w_owner + 2'd1) : r_ptr;

    rr_pick4 u_pick (
        .req        (req),
        .ptr        (w_pick_ptr),
        .win_onehot (w_win_onehot),
        .win_idx    (w_win_idx),
        .any        (w_any)
    );

    // Ownership FSM, priority pointer, beat counter and timeout pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_sel     <= '0;
            r_ptr     <= '0;
            r_count   <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_state <= ST_OWN;
                        r_grant <= w_win_onehot;
                        r_sel   <= w_win_idx;
                        r_count <= '0;
                    end
                end
                ST_OWN: begin
                    if (w_release) begin
                        r_ptr     <= w_pick_ptr;
                        r_count   <= '0;
                        r_timeout <= w_rel_force;
                        if (w_any) begin
                            r_grant <= w_win_onehot;
                            r_sel   <= w_win_idx;
                        end else begin
                            r_state <= ST_IDLE;
                            r_grant <= '0;
                        end
                    end else if (w_beat) begin
                        r_count <= r_count + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

    assign grant   = r_grant;
    assign sel     = r_sel;
    assign busy    = |r_grant;
    assign timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter4.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter4
//  Description : Scoreboard bench for mem_port_arbiter4. The stimulus process
//                advances a behavioural owner/pointer model and queues the
//                expected outputs; a monitor pops and compares every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter4;

    localparam int MAX_BEATS = 16;
    localparam int CNT_W     = 5;

    typedef struct {
        logic [7:0] v;      // {grant, sel, busy, timeout}
        string      tag;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] last;
    logic       ready;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;
    logic       timeout;

    exp_t  exp_q[$];
    int    errors = 0;
    int    checks = 0;
    string phase  = "reset";

    // Reference model state: owner (-1 none), pointer, beats taken, sel, pulse
    int m_owner = -1;
    int m_ptr   = 0;
    int m_beats = 0;
    int m_sel   = 0;
    bit m_tmo   = 1'b0;
    int n_tmo   = 0;

    mem_port_arbiter4 #(.MAX_BEATS(MAX_BEATS), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .last    (last),
        .ready   (ready),
        .grant   (grant),
        .sel     (sel),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [7:0] model_vec();
        logic [3:0] g;
        g = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
        return {g, 2'(m_sel), (m_owner >= 0), m_tmo};
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_beats = 0;
        m_sel   = 0;
        m_tmo   = 1'b0;
    endtask

    // One cycle: apply inputs at the falling edge and queue what the next
    // rising edge must produce.
    task automatic drive_rn(input logic [3:0] r, input logic [3:0] l,
                            input logic rd, input logic rn);
        exp_t e;
        int   w;
        bit   rel;
        @(negedge clk);
        req = r; last = l; ready = rd; rst_n = rn;
        m_tmo = 1'b0;
        if (!rn) begin
            model_reset();
        end else if (m_owner < 0) begin
            w = pick(r, m_ptr);
            if (w >= 0) begin
                m_owner = w; m_sel = w; m_beats = 0;
            end
        end else begin
            rel = 1'b0;
            if (!r[m_owner]) begin
                rel = 1'b1;
            end else if (rd) begin
                m_beats++;
                if (l[m_owner]) rel = 1'b1;
                else if (m_beats == MAX_BEATS) begin
                    rel = 1'b1; m_tmo = 1'b1; n_tmo++;
                end
            end
            if (rel) begin
                m_ptr   = (m_owner + 1) % 4;
                m_beats = 0;
                w = pick(r, m_ptr);
                if (w >= 0) begin
                    m_owner = w; m_sel = w;
                end else begin
                    m_owner = -1;
                end
            end
        end
        e.v   = model_vec();
        e.tag = phase;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic [3:0] r, input logic [3:0] l, input logic rd);
        drive_rn(r, l, rd, 1'b1);
    endtask

    task automatic check_now(input string name, input logic [7:0] want);
        logic [7:0] act;
        act = {grant, sel, busy, timeout};
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got grant=%b sel=%0d busy=%b timeout=%b, want grant=%b sel=%0d busy=%b timeout=%b",
                     name, act[7:4], act[3:2], act[1], act[0],
                     want[7:4], want[3:2], want[1], want[0]);
        end
    endtask

    // Monitor: compare registered outputs shortly after every rising edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_now(e.tag, e.v);
            end
        end
    end

    initial begin
        logic [3:0] hold_r;
        int         mode;
        rst_n = 1'b1; req = '0; last = '0; ready = 1'b0;

        // Asynchronous reset takes effect without a clock edge
        #2 rst_n = 1'b0;
        #1 check_now("reset_async", 8'h00);
        drive_rn(4'b1111, 4'b0000, 1'b1, 1'b0);
        drive_rn(4'b1111, 4'b0000, 1'b1, 1'b0);

        // Single burst from requester 0, last on third beat
        phase = "single_burst";
        drive(4'b0001, 4'b0000, 1'b1);
        drive(4'b0001, 4'b0000, 1'b1);
        drive(4'b0001, 4'b0000, 1'b1);
        drive(4'b0001, 4'b0001, 1'b1);
        drive(4'b0000, 4'b0000, 1'b1);
        drive(4'b0000, 4'b0000, 1'b1);

        // Back-to-back rotation with single-beat bursts
        phase = "rotation";
        for (int i = 0; i < 7; i++) drive(4'b1111, 4'b1111, 1'b1);
        drive(4'b0000, 4'b0000, 1'b1);
        drive(4'b0000, 4'b0000, 1'b1);

        // Forced release of a lone requester after MAX_BEATS beats
        phase = "forced_release";
        for (int i = 0; i < 2 * MAX_BEATS + 6; i++) drive(4'b0100, 4'b0000, 1'b1);
        drive(4'b0000, 4'b0000, 1'b1);

        // Stall after two beats, then finish normally
        phase = "stall";
        drive(4'b0010, 4'b0000, 1'b1);
        drive(4'b0010, 4'b0000, 1'b1);
        drive(4'b0010, 4'b0000, 1'b1);
        for (int i = 0; i < 5; i++) drive(4'b0010, 4'b0010, 1'b0);
        for (int i = 0; i < MAX_BEATS - 4; i++) drive(4'b0010, 4'b0000, 1'b1);
        drive(4'b0010, 4'b0010, 1'b1);
        drive(4'b0000, 4'b0000, 1'b1);

        // Owner 2 abandons while 0 and 3 wait; 3 is next after the pointer
        phase = "abandon";
        drive(4'b0100, 4'b0000, 1'b1);
        drive(4'b0100, 4'b0000, 1'b1);
        drive(4'b1001, 4'b0000, 1'b0);
        drive(4'b1001, 4'b1000, 1'b1);
        drive(4'b0001, 4'b0001, 1'b1);
        drive(4'b0000, 4'b0000, 1'b1);

        // Reset between clock edges in the middle of a burst
        phase = "reset_mid";
        drive(4'b0100, 4'b0000, 1'b1);
        drive(4'b0100, 4'b0000, 1'b1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_now("reset_mid_async", 8'h00);
        model_reset();
        drive_rn(4'b0100, 4'b0000, 1'b1, 1'b0);
        drive(4'b1111, 4'b0000, 1'b1);
        drive(4'b1111, 4'b1111, 1'b1);
        drive(4'b0000, 4'b0000, 1'b1);

        // Randomized traffic in modes: persistent long bursts or churn
        phase  = "random";
        hold_r = 4'b0000;
        mode   = 0;
        for (int i = 0; i < 2000; i++) begin
            logic [3:0] l;
            logic       rd;
            if (i % 100 == 0) mode = int'($urandom_range(0, 2));
            for (int b = 0; b < 4; b++) begin
                if (mode == 2) hold_r[b] = ($urandom_range(0, 9) < 6);
                else if ($urandom_range(0, 29) == 0) hold_r[b] = ~hold_r[b];
            end
            for (int b = 0; b < 4; b++)
                l[b] = (mode == 0) ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 5) == 0);
            rd = ($urandom_range(0, 9) < 8);
            if ($urandom_range(0, 599) == 0) drive_rn(hold_r, l, rd, 1'b0);
            else drive(hold_r, l, rd);
        end
        drive(4'b0000, 4'b0000, 1'b1);
        drive(4'b0000, 4'b0000, 1'b1);

        @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
